// File: rtl/rvv_backend_pmtrdt_issue.sv
// rtl/rvv_backend_pmtrdt_issue.sv - in-order issue from the PMTRDT RS to the pmtrdt units
//
// Each cycle inspects the two oldest RS slots and pops a prefix of 0, 1 or 2 of them.
// Special uops (RDT/CMP/COMPRESS) go to unit 0 only; PMT uops go to any unit by round-robin.
// Each unit has one output register and a capped in-flight counter.
//
// Ports:
//   clk, rst (async, active-high), flush (sync)
//   rs_vld/rs_cls/rs_last/rs_uop : two oldest RS slots; rs_pop : pop mask (00/01/11)
//   unit_vld/unit_uop/unit_rdy   : per-unit issue handshake
//   unit_done                    : per-unit completion pulse
//   lock0                        : unit 0 bound to a multi-uop special instruction
module rvv_backend_pmtrdt_issue #(
    parameter int NUM_UNIT = 2,
    parameter int UOP_W    = 128,
    parameter int MAX_INFL = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [1:0]                     rs_vld,
    input  logic [1:0][1:0]                rs_cls,
    input  logic [1:0]                     rs_last,
    input  logic [1:0][UOP_W-1:0]          rs_uop,
    output logic [1:0]                     rs_pop,
    output logic [NUM_UNIT-1:0]            unit_vld,
    output logic [NUM_UNIT-1:0][UOP_W-1:0] unit_uop,
    input  logic [NUM_UNIT-1:0]            unit_rdy,
    input  logic [NUM_UNIT-1:0]            unit_done,
    output logic                           lock0
);

    localparam int RR_W = $clog2(NUM_UNIT);
    // One extra bit of headroom: the OR handshake is not gated by the cap.
    localparam logic [2:0] MAX_I = 3'(MAX_INFL);
    localparam logic [0:0] LK_IDLE   = 1'b0;
    localparam logic [0:0] LK_LOCKED = 1'b1;

    logic [NUM_UNIT-1:0][2:0] infl;
    logic [NUM_UNIT-1:0][2:0] infl_dec;
    logic [NUM_UNIT-1:0]      hs;
    logic [NUM_UNIT-1:0]      elig;
    logic [NUM_UNIT-1:0]      avail1;
    logic [RR_W-1:0]          rr, rr_mid, rr_nxt;
    logic [0:0]               lk_state;
    logic                     lock_mid, lock_nxt;
    logic                     g0, g1;
    logic [RR_W-1:0]          sel0, sel1;
    logic [RR_W:0]            p0, p1;

    assign lock0 = (lk_state == LK_LOCKED);

    // Returns {found, unit}: first set bit of mask scanning from start with wrap-around.
    function automatic logic [RR_W:0] pick(input logic [RR_W-1:0] start, input logic [NUM_UNIT-1:0] mask);
        logic [RR_W:0] res;
        int j;
        res = '0;
        for (int i = 0; i < NUM_UNIT; i++) begin
            j = int'(start) + i;
            if (j >= NUM_UNIT) j = j - NUM_UNIT;
            if (!res[RR_W] && mask[j]) res = {1'b1, RR_W'(j)};
        end
        return res;
    endfunction

    function automatic logic [RR_W-1:0] rr_after(input logic [RR_W-1:0] idx);
        return (int'(idx) == NUM_UNIT - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        for (int u = 0; u < NUM_UNIT; u++) begin
            hs[u]       = unit_vld[u] & unit_rdy[u];
            infl_dec[u] = infl[u] - {2'b00, (unit_done[u] && infl[u] != 3'd0)};
            elig[u]     = (!unit_vld[u] || unit_rdy[u]) && (infl_dec[u] < MAX_I);
        end

        g0 = 1'b0; sel0 = '0; rr_mid = rr; lock_mid = lock0;
        p0 = pick(rr, elig);
        if (!flush && rs_vld[0]) begin
            if (rs_cls[0] != 2'd0) begin
                if (elig[0]) begin
                    g0 = 1'b1;
                    lock_mid = !rs_last[0];
                end
            end else if (!lock0 && p0[RR_W]) begin
                // A PMT head under lock is a class mismatch and simply stalls.
                g0 = 1'b1;
                sel0 = p0[RR_W-1:0];
                rr_mid = rr_after(p0[RR_W-1:0]);
            end
        end

        avail1 = elig;
        avail1[sel0] = 1'b0;
        g1 = 1'b0; sel1 = '0; rr_nxt = rr_mid; lock_nxt = lock_mid;
        p1 = pick(rr_mid, avail1);
        if (g0 && rs_vld[1]) begin
            if (rs_cls[1] != 2'd0) begin
                if (avail1[0]) begin
                    g1 = 1'b1;
                    lock_nxt = !rs_last[1];
                end
            end else if (!lock0 && !lock_mid && p1[RR_W]) begin
                // A PMT uop waits to become the oldest slot while unit 0 is locked.
                g1 = 1'b1;
                sel1 = p1[RR_W-1:0];
                rr_nxt = rr_after(p1[RR_W-1:0]);
            end
        end
        rs_pop = {g1, g0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_vld <= '0;
            unit_uop <= '0;
            infl     <= '0;
            rr       <= RR_W'(1);
            lk_state <= LK_IDLE;
        end else if (flush) begin
            unit_vld <= '0;
            infl     <= '0;
            rr       <= RR_W'(1);
            lk_state <= LK_IDLE;
        end else begin
            for (int u = 0; u < NUM_UNIT; u++) begin
                infl[u] <= infl_dec[u] + {2'b00, hs[u]};
                if (hs[u]) unit_vld[u] <= 1'b0;
                if (g0 && sel0 == RR_W'(u)) begin
                    unit_vld[u] <= 1'b1;
                    unit_uop[u] <= rs_uop[0];
                end
                if (g1 && sel1 == RR_W'(u)) begin
                    unit_vld[u] <= 1'b1;
                    unit_uop[u] <= rs_uop[1];
                end
            end
            rr       <= rr_nxt;
            lk_state <= lock_nxt ? LK_LOCKED : LK_IDLE;
        end
    end

    for (genvar g = 0; g < NUM_UNIT; g++) begin : g_sva
        a_done_underflow: assert property (@(posedge clk) disable iff (rst)
            !(unit_done[g] && infl[g] == 3'd0));
    end
    a_class_mismatch: assert property (@(posedge clk) disable iff (rst || flush)
        !(lock0 && rs_vld[0] && rs_cls[0] == 2'd0));
    a_pop_prefix: assert property (@(posedge clk) disable iff (rst) rs_pop != 2'b10);

endmodule
